// File: rtl/rename_alloc_ctrl_if.sv
// Dispatch/free-list bundle seen by the rename allocation controller.
// The master side drives dispatch and free-list state; the slave side returns grants.
interface rename_alloc_ctrl_if #(
  parameter int WAYS = 4,
  parameter int PRF  = 64
);
  localparam int IW = $clog2(PRF);

  logic                     except;
  logic [WAYS-1:0]          dispatch_valid;
  logic [WAYS-1:0]          dispatch_has_dest;
  logic                     downstream_ready;
  logic [WAYS-1:0]          fl_valid;
  logic [WAYS-1:0][IW-1:0]  fl_idx;
  logic [WAYS-1:0]          needed;
  logic [WAYS-1:0]          grant;
  logic [WAYS-1:0][IW-1:0]  dest_prf;
  logic                     stall;
  logic                     starve;
  logic [31:0]              alloc_total;

  modport master (
    output except, dispatch_valid, dispatch_has_dest,
    output downstream_ready, fl_valid, fl_idx,
    input  needed, grant, dest_prf, stall, starve, alloc_total
  );

  modport slave (
    input  except, dispatch_valid, dispatch_has_dest,
    input  downstream_ready, fl_valid, fl_idx,
    output needed, grant, dest_prf, stall, starve, alloc_total
  );
endinterface

// File: rtl/rename_alloc_ctrl.sv
// Grants an in-order prefix of dispatch ways and maps dest ways to free-list slots.
// Allocation is blocked while free-list outputs are stale (after consumption or flush).
module rename_alloc_ctrl #(
  parameter int WAYS           = 4,
  parameter int PRF            = 64,
  parameter int RECOVER_CYCLES = 1,
  parameter int STALL_LIMIT    = 8
) (
  input logic               clock,
  input logic               reset,
  rename_alloc_ctrl_if.slave io
);
  localparam int IW = $clog2(PRF);
  localparam int CW = $clog2(RECOVER_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    COOLDOWN = 2'd1,
    RECOVER  = 2'd2
  } state_e;

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [7:0]              stall_cnt_q;
  logic [31:0]             total_q;

  logic [WAYS-1:0]         grant_d;
  logic [WAYS-1:0]         needed_d;
  logic [WAYS-1:0][IW-1:0] dest_d;

  always_comb begin : alloc
    logic            ok;
    logic [WAYS-1:0] avail;
    logic [WAYS-1:0] pick;
    ok       = (state_q == RUN) && io.downstream_ready && !io.except;
    avail    = io.fl_valid;
    pick     = '0;
    grant_d  = '0;
    needed_d = '0;
    dest_d   = '0;
    for (int i = 0; i < WAYS; i++) begin
      // lowest unused valid slot, isolated as a one-hot
      pick = avail & (~avail + WAYS'(1));
      if (ok && io.dispatch_valid[i] &&
          (!io.dispatch_has_dest[i] || (|avail))) begin
        grant_d[i] = 1'b1;
        if (io.dispatch_has_dest[i]) begin
          needed_d = needed_d | pick;
          avail    = avail & ~pick;
          for (int k = 0; k < WAYS; k++) begin
            if (pick[k]) dest_d[i] = io.fl_idx[k];
          end
        end
      end else begin
        ok = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RECOVER;
      cnt_q       <= CW'(RECOVER_CYCLES);
      stall_cnt_q <= '0;
      total_q     <= '0;
    end else begin
      total_q <= total_q + 32'($countones(needed_d));
      if (io.except) begin
        state_q     <= RECOVER;
        cnt_q       <= CW'(RECOVER_CYCLES);
        stall_cnt_q <= '0;
      end else begin
        unique case (state_q)
          RECOVER: begin
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_q <= RUN;
          end
          RUN: begin
            if (|needed_d) state_q <= COOLDOWN;
          end
          COOLDOWN: state_q <= RUN;
          default:  state_q <= RECOVER;
        endcase
        if (io.dispatch_valid[0] && !grant_d[0]) begin
          if (stall_cnt_q != 8'hFF) stall_cnt_q <= stall_cnt_q + 8'd1;
        end else begin
          stall_cnt_q <= '0;
        end
      end
    end
  end

  assign io.grant       = grant_d;
  assign io.needed      = needed_d;
  assign io.dest_prf    = dest_d;
  assign io.stall       = |(io.dispatch_valid & ~grant_d);
  assign io.starve      = (stall_cnt_q >= 8'(STALL_LIMIT));
  assign io.alloc_total = total_q;
endmodule
